ring_stop_game: RTL
===================

# ring_stop_game

Reaction-game controller that drives the enable of the 15-bit five-position ring counter and judges the player's button press against the lit position. It generates the ring step tick, debounces the push button, and scores each press as hit or miss. Score, lives and speed level go to the display stage. It sits directly downstream of the ring counter, consuming its `count` bus, and also feeds that counter's `en` input.

## Interface
- `STEP_DIV`, 25_000_000 — clocks per ring step at level 0; must be ≥ 16.
- `DEB_CYC`, 1_000_000 — cycles the button must be stable before it is accepted.
- `FREEZE_CYC`, 50_000_000 — cycles the ring is held after a press.
- `TARGET`, 14 — bit index of `count` that counts as a hit; one of 2, 5, 8, 11, 14.
- `MAX_LIVES`, 3 — lives at game start, 1..3.
- `SCORE_W`, 8 — score width.

Ports:
- `clk`  in  1  — single system clock.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — raw start switch/button, asynchronous to `clk`.
- `btn`  in  1  — raw player push button, asynchronous and bouncy.
- `count`  in  15  — ring counter state, one-hot on bits {2,5,8,11,14}.
- `ring_en`  out  1  — one-cycle step pulse to the ring counter `en`.
- `hit`  out  1  — one-cycle pulse: press judged a hit.
- `miss`  out  1  — one-cycle pulse: press judged a miss.
- `score`  out  SCORE_W  — hits this game, saturating.
- `lives`  out  2  — remaining lives.
- `level`  out  2  — speed level 0..3.
- `state`  out  2  — IDLE=0, RUN=1, FREEZE=2, OVER=3.

## Operation
- Reset values: `state` = IDLE, `score` = 0, `lives` = MAX_LIVES, `level` = 0, `ring_en`/`hit`/`miss` = 0. All internal counters and synchronizers are cleared.
- **Inputs.** `btn` and `start` each pass through a 2-FF synchronizer.
  - Button debounce: the debounced level `btn_db` takes the synchronized value only after that value has differed from `btn_db` for DEB_CYC consecutive cycles. Any return to equality restarts the count.
  - `press` = rising edge of `btn_db`, one cycle wide.
  - `start_p` = rising edge of synchronized `start`, not debounced.
- **Step divider.** Runs only in RUN.
  - Period P = STEP_DIV >> `level`.
  - The divider counts 0..P-1. `ring_en` pulses in the cycle the count equals P-1, then the count wraps to 0.
  - The divider is cleared on every entry to RUN and on a `level` change.
- **State machine.**
  - IDLE: on `start_p`, clear score to 0, set lives = MAX_LIVES, level = 0, then go to RUN.
  - RUN: on `press`, evaluate `count[TARGET]`.
    - If 1: pulse `hit`, score += 1 (saturating at all-ones), level += 1 (saturating at 3).
    - If 0: pulse `miss`, lives -= 1.
    - In both cases, clear the freeze counter and go to FREEZE.
    - `start_p` is ignored in RUN.
  - FREEZE: `ring_en` is held at 0. After FREEZE_CYC cycles, go to RUN if lives > 0, otherwise go to OVER.
  - OVER: on `start_p`, perform the same initialisation as IDLE and go to RUN.
- `press` in IDLE, FREEZE or OVER is discarded and not queued.
- `count` is sampled as-is with no validity check. A non-one-hot value is judged only on bit TARGET.

## Timing
- Press path latency:
  - raw `btn` edge → synchronized after 2 cycles;
  - plus DEB_CYC cycles → `btn_db` rises;
  - `press` is high in the next cycle.
- `hit`/`miss`, `score`, `lives`, `level` and `state` = FREEZE all update together on the clock edge that samples `press`. They are visible one cycle after `press`.
- Simultaneous `press` and divider terminal count in RUN: the press wins. `ring_en` is suppressed that cycle, so `count` is judged before the ring moves.
- `ring_en` first pulses P cycles after `state` becomes RUN. It never pulses in IDLE, FREEZE or OVER.
- `start_p` coincident with `press` in IDLE/OVER: the start is taken and the press is discarded.
- Asserting `rst_n` mid-game forces all reset values immediately, independent of `clk`. Any `ring_en` pulse in flight is cut.

## Test plan
All scenarios use STEP_DIV=16, DEB_CYC=4, FREEZE_CYC=6, MAX_LIVES=3, TARGET=14, with a behavioural ring counter model in the bench.
- **Reset and start.** Release reset, then pulse `start` → `state` goes 0→1; first `ring_en` exactly 16 cycles after RUN entry; pulses every 16 cycles after that; `lives`=3, `score`=0.
- **Bounce.** Toggle `btn` with 3-cycle glitches, then hold it high for 10 cycles → exactly one `press`, and exactly one `hit` or `miss`.
- **Hit and speed-up.** Press while `count[14]`=1 → `hit`=1 for one cycle, `score`=1, `level`=1, `state`=2. Hold FREEZE 6 cycles with no `ring_en`, then RUN with period 8.
- **Miss to game over.** Press three times while `count[14]`=0 → `lives` goes 3→2→1→0; `miss` pulses each time; after the last freeze `state`=3. Then pulse `start` → RUN with `lives`=3, `score`=0.
- **Collision.** Align `press` with the divider terminal count → no `ring_en` that cycle; judgement uses the pre-step `count`.
- **Saturation and reset.** Hit repeatedly → `level` stops at 3 (period 2). Assert `rst_n` low mid-FREEZE → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ring_stop_game.sv
// Reaction-game controller: paces the five-position ring counter, debounces the
// player button and scores each press against the lit ring position.
module ring_stop_game #(
  parameter int unsigned STEP_DIV   = 25_000_000,
  parameter int unsigned DEB_CYC    = 1_000_000,
  parameter int unsigned FREEZE_CYC = 50_000_000,
  parameter int unsigned TARGET     = 14,
  parameter int unsigned MAX_LIVES  = 3,
  parameter int unsigned SCORE_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               btn,
  input  logic [14:0]        count,
  output logic               ring_en,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic [1:0]         level,
  output logic [1:0]         state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FREEZE = 2'd2;
  localparam logic [1:0] S_OVER   = 2'd3;

  localparam int unsigned DIV_W = $clog2(STEP_DIV + 1);
  localparam int unsigned DEB_W = $clog2(DEB_CYC + 1);
  localparam int unsigned FRZ_W = $clog2(FREEZE_CYC + 1);

  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYC - 1);
  localparam logic [FRZ_W-1:0]   FRZ_LAST   = FRZ_W'(FREEZE_CYC - 1);
  localparam logic [1:0]         LIVES_INIT = 2'(MAX_LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  logic               r_btn_s1, r_btn_s2;
  logic               r_start_s1, r_start_s2, r_start_d;
  logic [DEB_W-1:0]   r_deb_cnt;
  logic               r_btn_db, r_btn_db_d;
  logic [1:0]         r_state;
  logic [SCORE_W-1:0] r_score;
  logic [1:0]         r_lives;
  logic [1:0]         r_level;
  logic               r_hit, r_miss;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [FRZ_W-1:0]   r_frz_cnt;

  logic               w_press;
  logic               w_start_p;
  logic [DIV_W-1:0]   w_div_last;
  logic               w_div_tc;
  logic               w_unused;

  // Only the target bit of the ring is judged; the rest is intentionally ignored.
  assign w_unused = ^count;

  assign w_press    = r_btn_db & ~r_btn_db_d;
  assign w_start_p  = r_start_s2 & ~r_start_d;
  assign w_div_last = DIV_W'((STEP_DIV >> r_level) - 1);
  assign w_div_tc   = (r_div_cnt == w_div_last);

  // A press in the terminal-count cycle wins: the step is withheld so the
  // judged position is the one the player saw.
  assign ring_en = (r_state == S_RUN) && w_div_tc && !w_press;

  assign hit   = r_hit;
  assign miss  = r_miss;
  assign score = r_score;
  assign lives = r_lives;
  assign level = r_level;
  assign state = r_state;

  // Two-flop synchronizers for the asynchronous start and button inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_s1   <= 1'b0;
      r_btn_s2   <= 1'b0;
      r_start_s1 <= 1'b0;
      r_start_s2 <= 1'b0;
      r_start_d  <= 1'b0;
    end else begin
      r_btn_s1   <= btn;
      r_btn_s2   <= r_btn_s1;
      r_start_s1 <= start;
      r_start_s2 <= r_start_s1;
      r_start_d  <= r_start_s2;
    end
  end

  // Debounce: accept a new button level only after it has persisted DEB_CYC cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb_cnt  <= '0;
      r_btn_db   <= 1'b0;
      r_btn_db_d <= 1'b0;
    end else begin
      r_btn_db_d <= r_btn_db;
      if (r_btn_s2 != r_btn_db) begin
        if (r_deb_cnt == DEB_LAST) begin
          r_btn_db  <= r_btn_s2;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + DEB_W'(1);
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  // Game state machine with step divider, freeze timer and scoring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_score   <= '0;
      r_lives   <= LIVES_INIT;
      r_level   <= 2'd0;
      r_hit     <= 1'b0;
      r_miss    <= 1'b0;
      r_div_cnt <= '0;
      r_frz_cnt <= '0;
    end else begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      case (r_state)
        S_IDLE, S_OVER: begin
          r_div_cnt <= '0;
          if (w_start_p) begin
            r_score <= '0;
            r_lives <= LIVES_INIT;
            r_level <= 2'd0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_press) begin
            if (count[TARGET]) begin
              r_hit <= 1'b1;
              if (r_score != SCORE_MAX) r_score <= r_score + SCORE_W'(1);
              if (r_level != 2'd3)      r_level <= r_level + 2'd1;
            end else begin
              r_miss <= 1'b1;
              if (r_lives != 2'd0) r_lives <= r_lives - 2'd1;
            end
            r_frz_cnt <= '0;
            r_div_cnt <= '0;
            r_state   <= S_FREEZE;
          end else if (w_div_tc) begin
            r_div_cnt <= '0;
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        S_FREEZE: begin
          r_div_cnt <= '0;
          if (r_frz_cnt == FRZ_LAST) begin
            r_frz_cnt <= '0;
            r_state   <= (r_lives != 2'd0) ? S_RUN : S_OVER;
          end else begin
            r_frz_cnt <= r_frz_cnt + FRZ_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
